accum_sequencer: RTL and testbench

ACCUM_SEQUENCER -- requirements
Module: accum_sequencer

---
 rtl/accum_pkg.sv | 16 +
 rtl/interval_timer.sv | 33 +++
 rtl/accum_sequencer.sv | 107 ++++++++++
 tb/tb_accum_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// accum_pkg -- shared definitions for the accumulating sequencer.
//   state_t        : FSM state encoding (IDLE, LOAD, SHOW, WAIT, ADD)
//   DEFAULT_CLK_HZ : default clock frequency used by accum_sequencer
package accum_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      SHOW = 3'd2,
      WAIT = 3'd3,
      ADD  = 3'd4
   } state_t;

   localparam int DEFAULT_CLK_HZ = 100_000_000;

endpackage

// File: rtl/interval_timer.sv
// interval_timer -- counts enabled cycles and pulses tick on the last one.
// Parameters:
//   CYCLES : interval length in clk cycles (>= 1)
// Ports:
//   clk    : clock, rising edge
//   btnU   : asynchronous active-high reset
//   clear  : synchronous clear, has priority over enable
//   enable : count this cycle
//   tick   : high during the CYCLES-th enabled cycle after a clear
module interval_timer #(
   parameter int CYCLES = 10
) (
   input  logic clk,
   input  logic btnU,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int            CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

   logic [CW-1:0] cnt;

   assign tick = enable && !clear && (cnt == LAST);

   always_ff @(posedge clk or posedge btnU) begin
      if (btnU)        cnt <= '0;
      else if (clear)  cnt <= '0;
      else if (enable) cnt <= tick ? '0 : cnt + CW'(1);
   end

endmodule

// File: rtl/accum_sequencer.sv
// accum_sequencer -- loads start_val, then adds incr once every N_SEC
// seconds, handshaking each new sum with a display via disp_start/disp_done.
// Parameters:
//   CLK_HZ : clk frequency in Hz
//   N_SEC  : seconds between accumulation steps (1..15)
//   W      : accumulator width
// Ports:
//   clk        : clock, rising edge
//   btnU       : asynchronous active-high reset
//   run        : level enable (1 = sequence, 0 = return to IDLE and hold)
//   start_val  : first value, sampled in LOAD only
//   incr       : step, sampled in ADD only
//   disp_done  : display finished showing sum (used in SHOW only)
//   sum        : accumulator
//   disp_start : one-cycle pulse, new sum ready
//   ovf        : sticky overflow flag, cleared by LOAD
//   busy       : FSM not in IDLE
//   led        : combinational mirror of sum
// Build option: define ACCUM_SATURATE_EN to clamp sum at 2^W-1 on overflow
// instead of wrapping.
module accum_sequencer
   import accum_pkg::*;
#(
   parameter int CLK_HZ = DEFAULT_CLK_HZ,
   parameter int N_SEC  = 1,
   parameter int W      = 16
) (
   input  logic         clk,
   input  logic         btnU,
   input  logic         run,
   input  logic [W-1:0] start_val,
   input  logic [W-1:0] incr,
   input  logic         disp_done,
   output logic [W-1:0] sum,
   output logic         disp_start,
   output logic         ovf,
   output logic         busy,
   output logic [W-1:0] led
);

   localparam int INTERVAL = N_SEC * CLK_HZ;

   state_t       state;
   logic         tick;
   logic [W:0]   add_full;
   logic [W-1:0] add_res;

   // The counter is held clear outside WAIT, so it always starts from zero
   // on WAIT entry and ADD is entered exactly INTERVAL cycles later.
   interval_timer #(.CYCLES(INTERVAL)) u_timer (
      .clk    (clk),
      .btnU   (btnU),
      .clear  (state != WAIT),
      .enable (state == WAIT),
      .tick   (tick)
   );

   assign add_full = {1'b0, sum} + {1'b0, incr};

`ifdef ACCUM_SATURATE_EN
   assign add_res = add_full[W] ? {W{1'b1}} : add_full[W-1:0];
`else
   assign add_res = add_full[W-1:0];
`endif

   assign led = sum;

   always_ff @(posedge clk or posedge btnU) begin
      if (btnU) begin
         state      <= IDLE;
         sum        <= '0;
         ovf        <= 1'b0;
         disp_start <= 1'b0;
         busy       <= 1'b0;
      end else begin
         disp_start <= 1'b0;
         case (state)
            IDLE: if (run) begin
               state <= LOAD;
               busy  <= 1'b1;
            end
            LOAD: begin
               sum        <= start_val;
               ovf        <= 1'b0;
               disp_start <= 1'b1;
               state      <= SHOW;
            end
            SHOW: if (disp_done) state <= WAIT;
            WAIT: if (tick) state <= ADD;
            ADD: begin
               sum        <= add_res;
               ovf        <= ovf | add_full[W];
               disp_start <= 1'b1;
               state      <= SHOW;
            end
            default: state <= IDLE;
         endcase
         // Dropping run lets this cycle's action complete, then parks in
         // IDLE with sum and ovf held.
         if (!run) begin
            state <= IDLE;
            busy  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_accum_sequencer.sv
// tb_accum_sequencer -- scoreboard bench for accum_sequencer with
// CLK_HZ=10, N_SEC=1 (10-cycle interval). Stimulus pushes the expected
// {sum, ovf, gap} for every disp_start it provokes; the monitor pops one
// entry per pulse. gap is cycles since the previous pulse (0 = don't care):
// one SHOW cycle + 10 WAIT cycles + one ADD cycle = 12 with disp_done high.
module tb_accum_sequencer;

   logic        clk = 1'b0;
   logic        btnU = 1'b1;
   logic        run = 1'b0;
   logic        disp_done = 1'b1;
   logic [15:0] start_val = 16'd4;
   logic [15:0] incr = 16'd20;
   logic [15:0] sum, led;
   logic        disp_start, ovf, busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int pulse_cnt = 0;
   int last_pulse = 0;

   typedef struct {
      logic [15:0] sum;
      logic        ovf;
      int          gap;
   } exp_t;

   exp_t sb[$];
   exp_t e_mon;

`ifdef ACCUM_SATURATE_EN
   localparam logic [15:0] OVF_SUM1 = 16'hFFFF;
   localparam logic [15:0] OVF_SUM2 = 16'hFFFF;
`else
   localparam logic [15:0] OVF_SUM1 = 16'h0010;
   localparam logic [15:0] OVF_SUM2 = 16'h0030;
`endif

   accum_sequencer #(.CLK_HZ(10), .N_SEC(1), .W(16)) dut (
      .clk        (clk),
      .btnU       (btnU),
      .run        (run),
      .start_val  (start_val),
      .incr       (incr),
      .disp_done  (disp_done),
      .sum        (sum),
      .disp_start (disp_start),
      .ovf        (ovf),
      .busy       (busy),
      .led        (led)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: one scoreboard entry per disp_start pulse.
   always @(negedge clk) begin
      if (!btnU && disp_start) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_disp_start: got pulse with sum %0h, expected none (cycle %0d)", sum, cyc);
         end else begin
            e_mon = sb.pop_front();
            check("pulse_sum", 32'(sum), 32'(e_mon.sum));
            check("pulse_led", 32'(led), 32'(e_mon.sum));
            check("pulse_ovf", 32'(ovf), 32'(e_mon.ovf));
            if (e_mon.gap != 0) check("pulse_gap", 32'(cyc - last_pulse), 32'(e_mon.gap));
         end
         pulse_cnt++;
         last_pulse = cyc;
      end
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_pulses(input int target, input int budget);
      int n;
      n = 0;
      while (pulse_cnt < target && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("pulse_count", 32'(pulse_cnt), 32'(target));
   endtask

   initial begin
      int c;
      // Reset state
      cycles(3);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_disp_start", 32'(disp_start), 32'd0);
      check("rst_led", 32'(led), 32'd0);
      btnU = 1'b0;
      cycles(2);
      check("idle_busy", 32'(busy), 32'd0);

      // Basic sequence 4, 24, 44; start_val changes after LOAD are ignored
      sb.push_back('{16'd4, 1'b0, 0});
      sb.push_back('{16'd24, 1'b0, 12});
      sb.push_back('{16'd44, 1'b0, 12});
      run = 1'b1;
      wait_pulses(1, 20);
      start_val = 16'd999;
      wait_pulses(3, 60);
      check("run_busy", 32'(busy), 32'd1);

      // Reset mid-WAIT takes effect without a clock edge
      cycles(5);
      btnU = 1'b1;
      #1;
      check("midrst_sum", 32'(sum), 32'd0);
      check("midrst_ovf", 32'(ovf), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_disp_start", 32'(disp_start), 32'd0);
      start_val = 16'd4;
      sb.push_back('{16'd4, 1'b0, 0});
      sb.push_back('{16'd24, 1'b0, 12});
      cycles(3);
      btnU = 1'b0;
      wait_pulses(5, 60);

      // Drop run at 24: IDLE, hold, no pulses
      run = 1'b0;
      cycles(3);
      check("hold_busy", 32'(busy), 32'd0);
      check("hold_sum", 32'(sum), 32'd24);
      cycles(30);
      check("hold_sum_late", 32'(sum), 32'd24);
      check("hold_no_pulse", 32'(pulse_cnt), 32'd5);
      sb.push_back('{16'd4, 1'b0, 0});
      run = 1'b1;
      wait_pulses(6, 20);

      // Overflow: wrap or saturate depending on build
      run = 1'b0;
      cycles(2);
      start_val = 16'hFFF0;
      incr = 16'h0020;
      sb.push_back('{16'hFFF0, 1'b0, 0});
      sb.push_back('{OVF_SUM1, 1'b1, 12});
      sb.push_back('{OVF_SUM2, 1'b1, 12});
      run = 1'b1;
      wait_pulses(9, 60);
      run = 1'b0;
      cycles(2);
      check("ovf_held", 32'(ovf), 32'd1);
      check("ovf_sum_held", 32'(sum), 32'(OVF_SUM2));

      // Restart clears ovf through LOAD
      start_val = 16'd4;
      incr = 16'd20;
      sb.push_back('{16'd4, 1'b0, 0});
      run = 1'b1;
      wait_pulses(10, 20);

      // disp_done held low: stalls in SHOW
      run = 1'b0;
      cycles(2);
      disp_done = 1'b0;
      sb.push_back('{16'd4, 1'b0, 0});
      run = 1'b1;
      wait_pulses(11, 20);
      cycles(50);
      check("stall_sum", 32'(sum), 32'd4);
      check("stall_busy", 32'(busy), 32'd1);
      check("stall_no_pulse", 32'(pulse_cnt), 32'd11);
      c = cyc;
      sb.push_back('{16'd24, 1'b0, c + 12 - last_pulse});
      disp_done = 1'b1;
      wait_pulses(12, 30);
      run = 1'b0;
      cycles(2);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion before time 200000");
      $fatal(1, "watchdog timeout");
   end

endmodule
